hub75_rx_monitor: RTL

//  Receiving end of the HUB75 panel link: a panel emulator and loopback checker. Samples r1..b4,
//  clk_out, lat, blank, row_clk and row_data as driven by the HUB75 driver, rebuilds the shifted

---
 rtl/hub75_pkg.sv | 38 +++
 rtl/hub75_edge_sync.sv | 27 ++
 rtl/hub75_rx_monitor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// HUB75 shared definitions: panel geometry defaults, rgb lane positions,
// index widths and small helpers used by the driver and the rx monitor.
package hub75_pkg;

    localparam int COLS  = 64;
    localparam int ROWS  = 32;
    localparam int BITS  = 8;
    localparam int ROW_W = 8;
    localparam int BIT_W = 3;
    localparam int COL_W = 8;
    localparam int RGB_W = 12;

    // hub_rgb = {r1,g1,b1,r2,g2,b2,r3,g3,b3,r4,g4,b4}
    localparam int LANE_R1 = 11;
    localparam int LANE_G1 = 10;
    localparam int LANE_B1 = 9;
    localparam int LANE_R2 = 8;
    localparam int LANE_G2 = 7;
    localparam int LANE_B2 = 6;
    localparam int LANE_R3 = 5;
    localparam int LANE_G3 = 4;
    localparam int LANE_B3 = 3;
    localparam int LANE_R4 = 2;
    localparam int LANE_G4 = 1;
    localparam int LANE_B4 = 0;

    typedef enum logic {
        LINE_IDLE,
        LINE_SHIFT
    } line_state_t;

    function automatic logic [COL_W-1:0] sat_inc_col(
        input logic [COL_W-1:0] v
    );
        return (v == '1) ? v : v + COL_W'(1);
    endfunction

endpackage

// File: rtl/hub75_edge_sync.sv
// Synchroniser chain followed by a one-flop rising-edge detector.
// Ports: clk, rst (sync, high), din (async level), rise (1-cycle pulse).
module hub75_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/hub75_rx_monitor.sv
// HUB75 receive-side monitor: rebuilds pixel stream and row/plane sequencing.
// Ports: sys_clk/rst, hub_* link inputs, pix_* and line_* strobes, sticky errors.
module hub75_rx_monitor
    import hub75_pkg::*;
#(
    parameter int COLS        = hub75_pkg::COLS,
    parameter int ROWS        = hub75_pkg::ROWS,
    parameter int BITS        = hub75_pkg::BITS,
    parameter int SYNC_STAGES = 2,
    parameter int ON_W        = 16
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [11:0]      hub_rgb,
    input  logic             hub_clk,
    input  logic             hub_lat,
    input  logic             hub_blank,
    input  logic             hub_rclk,
    input  logic             hub_rdata,
    output logic             pix_valid,
    output logic [7:0]       pix_col,
    output logic [11:0]      pix_rgb,
    output logic             line_valid,
    output logic [7:0]       line_row,
    output logic [2:0]       line_bit,
    output logic [7:0]       line_cols,
    output logic [ON_W-1:0]  line_on,
    output logic             err_cols,
    output logic             err_plane
);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS - 1);
    localparam logic [COL_W-1:0] COLS_EXP  = COL_W'(COLS);
    localparam logic [ON_W-1:0]  ON_MAX    = '1;
    localparam int               DW        = RGB_W + 2;

    logic clk_r, lat_r, rclk_r;

    hub75_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (hub_clk),
        .rise (clk_r)
    );

    hub75_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (hub_lat),
        .rise (lat_r)
    );

    hub75_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (hub_rclk),
        .rise (rclk_r)
    );

    // Level-only inputs share one chain with the same depth as the edge
    // syncs, so data lines up with the edge that qualifies it.
    logic [DW-1:0] dsync [SYNC_STAGES];
    logic [11:0]   rgb_s;
    logic          rdata_s;
    logic          blank_s;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) dsync[i] <= '0;
        end else begin
            dsync[0] <= {hub_rgb, hub_rdata, hub_blank};
            for (int i = 1; i < SYNC_STAGES; i++) dsync[i] <= dsync[i-1];
        end
    end

    assign {rgb_s, rdata_s, blank_s} = dsync[SYNC_STAGES-1];

    line_state_t      state, state_n;
    logic [COL_W-1:0] col_cnt, col_a;
    logic [ROW_W-1:0] row_idx, row_a;
    logic [BIT_W-1:0] plane_cnt, plane_a;
    logic             plane_full, full_a;
    logic [ON_W-1:0]  on_cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) state <= LINE_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LINE_IDLE:  if (clk_r) state_n = LINE_SHIFT;
            LINE_SHIFT: state_n = LINE_SHIFT;
            default:    state_n = LINE_IDLE;
        endcase
        if (lat_r) state_n = LINE_IDLE;
    end

    // Same-cycle ordering: row clock first, then shift clock, then latch.
    always_comb begin
        row_a   = row_idx;
        plane_a = plane_cnt;
        full_a  = plane_full;
        if (rclk_r) begin
            plane_a = '0;
            full_a  = 1'b0;
            if (rdata_s || row_idx == ROW_LAST) row_a = '0;
            else                                row_a = row_idx + ROW_W'(1);
        end
        col_a = clk_r ? sat_inc_col(col_cnt) : col_cnt;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            pix_col    <= '0;
            pix_rgb    <= '0;
            line_valid <= 1'b0;
            line_row   <= '0;
            line_bit   <= '0;
            line_cols  <= '0;
            line_on    <= '0;
            err_cols   <= 1'b0;
            err_plane  <= 1'b0;
            col_cnt    <= '0;
            row_idx    <= '0;
            plane_cnt  <= '0;
            plane_full <= 1'b0;
            on_cnt     <= '0;
        end else begin
            pix_valid  <= clk_r;
            line_valid <= lat_r;
            row_idx    <= row_a;
            plane_cnt  <= plane_a;
            plane_full <= full_a;
            col_cnt    <= col_a;
            if (!blank_s && on_cnt != ON_MAX) on_cnt <= on_cnt + ON_W'(1);
            if (clk_r) begin
                pix_col <= col_cnt;
                pix_rgb <= rgb_s;
            end
            if (lat_r) begin
                line_row  <= row_a;
                line_bit  <= plane_a;
                line_cols <= col_a;
                line_on   <= on_cnt;
                col_cnt   <= '0;
                on_cnt    <= '0;
                if (col_a != COLS_EXP) err_cols <= 1'b1;
                // The last plane may be latched once; a repeat without
                // a row change is a sequencing error.
                if (plane_a == BIT_LAST) begin
                    plane_full <= 1'b1;
                    if (full_a) err_plane <= 1'b1;
                end else begin
                    plane_cnt <= plane_a + BIT_W'(1);
                end
            end
        end
    end

endmodule
